seq_addsub: RTL and testbench
=============================

# seq_addsub

Parametrised multi-cycle adder/subtractor: adds or subtracts two `WIDTH`-bit operands by rippling through `WIDTH/SLICE` slices, one slice per clock, with the carry held in a register between slices. It is the next generation of the core's 32-bit DSP-based adder. It trades latency for a narrow carry chain, so it can be used where no MAC16 tile is available. Operands enter and results leave on valid/ready handshakes, so the block can sit between the ALU operand latch and the writeback stage.

## Interface
- `WIDTH`, 32: operand and result width in bits.
- `SLICE`, 8: bits processed per clock. `WIDTH % SLICE != 0` or `SLICE > WIDTH` is an elaboration error.

Clock and reset: one clock; reset is synchronous and active-low.

- `clk` in 1: clock. All state updates on the rising edge.
- `rst_n` in 1: synchronous reset, active-low.
- `in_valid` in 1: operands valid.
- `in_ready` out 1: block can accept operands.
- `x` in WIDTH: minuend / augend.
- `y` in WIDTH: subtrahend / addend.
- `sub` in 1: 0 computes x+y; 1 computes x−y.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `out` out WIDTH: result.
- `carry_out` out 1: carry out of the MSB. For subtraction, 1 means no borrow (x ≥ y unsigned).
- `zero` out 1: `out == 0`.
- `negative` out 1: `out[WIDTH-1]`.
- `overflow` out 1: signed overflow.

## Operation
- NSL = WIDTH/SLICE. A slice index counter has ceil(log2(NSL)) bits, minimum 1.
- States:
  - IDLE: `in_ready`=1. The accept (`in_valid`&`in_ready`) latches `x`, `y` and `sub`, sets idx=0 and sets the carry register to `sub`. Next state is RUN.
  - RUN: each cycle computes {c, r} = x[idx] + (y[idx] ^ {SLICE{sub}}) + carry. r is written into result slice idx, carry←c and idx←idx+1. On the edge that computes slice NSL−1, the next state is DONE.
  - DONE: `out_valid`=1. On `out_ready`=1 the next state is IDLE.
- `in_ready` is high only in IDLE. There is no accept in the same cycle as result handoff.
- Latched operands are isolated from the inputs. Changes on `x`, `y` or `sub` after the accept have no effect.
- Result, `carry_out` and flags stay stable throughout DONE until the handshake completes.
- `overflow` = (x_msb == y'_msb) & (out_msb != x_msb), where y' is y after conditional inversion.
- SLICE == WIDTH is legal and gives a single RUN cycle.

## Timing
- Reset (`rst_n`=0 at a rising edge) forces IDLE, idx=0 and carry=0, and clears the result register, `carry_out` and the flags. After that edge, `in_ready`=1 and `out_valid`=0.
- Reset wins over every other event, including mid-RUN and in DONE with `out_ready`=1. An in-flight operation is discarded and produces no output.
- Latency: if the accept is at edge 0, `out_valid` rises after edge NSL (4 cycles for 32/8).
- Throughput: one operation per NSL+2 cycles with `out_ready` held high (accept, NSL RUN edges, handoff edge, back to IDLE).
- `in_ready` and `out_valid` are registered state decodes with no combinational path from `in_valid` or `out_ready`.

## Configuration
- `SEQ_ADDSUB_FLAGS_EN` defined: `zero`, `negative` and `overflow` are computed as above. They are registered together with the final slice and are valid whenever `out_valid`=1.
- Not defined: the three flag ports remain present, are tied to 0, and no flag logic is generated. `carry_out` is unaffected.

## Test plan
- Add, WIDTH=32 and SLICE=8: x=0x000000FF, y=0x00000001, sub=0, accept at cycle 0 -> `out_valid` at cycle 4, `out`=0x00000100, `carry_out`=0, `zero`=0.
- Carry across all slices: x=0xFFFFFFFF, y=0x00000001, sub=0 -> `out`=0x00000000, `carry_out`=1, `zero`=1, `overflow`=0.
- Subtract with borrow: x=5, y=7, sub=1 -> `out`=0xFFFFFFFE, `carry_out`=0, `negative`=1; x=7, y=5, sub=1 -> `out`=2, `carry_out`=1.
- Signed overflow: x=0x7FFFFFFF, y=1, sub=0 -> `out`=0x80000000, `overflow`=1, `negative`=1. Rebuild without `SEQ_ADDSUB_FLAGS_EN` -> same `out`, flags 0.
- Backpressure and isolation: after the accept, change `x` and `y` to random values and hold `out_ready`=0 for 10 cycles after `out_valid` -> `out` and `carry_out` stay stable and `in_ready`=0. Raise `out_ready` -> `in_ready`=1 on the next cycle.
- Reset mid-operation: drive `rst_n`=0 for one edge at cycle 2 of RUN -> after that edge `out_valid`=0 and `in_ready`=1, and `out_valid` stays 0 until a new accept. Repeat with SLICE=32: latency is 1 cycle.

Source files
------------

// File: rtl/seq_addsub.sv
`default_nettype none
// ============================================================================
// Module      : seq_addsub
// Description : Multi-cycle adder/subtractor. Ripples WIDTH/SLICE slices, one
//               slice per clock, with valid/ready handshakes on both sides.
//               Define SEQ_ADDSUB_FLAGS_EN to generate zero/negative/overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_addsub #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);

    localparam int c_NSL   = WIDTH / SLICE;
    localparam int c_IDX_W = (c_NSL > 1) ? $clog2(c_NSL) : 1;

    generate
        if ((WIDTH % SLICE != 0) || (SLICE > WIDTH)) begin : g_param_check
            $error("seq_addsub: WIDTH must be a multiple of SLICE and SLICE <= WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_accept;
    logic               w_last;

    logic [WIDTH-1:0]   r_x;
    logic [WIDTH-1:0]   r_y;
    logic               r_sub;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_carry;
    logic [WIDTH-1:0]   r_result;
    logic               r_cout;

    logic [SLICE-1:0]   w_x_slice;
    logic [SLICE-1:0]   w_y_slice;
    logic [SLICE:0]     w_sum;
    logic [WIDTH-1:0]   w_result_next;

    assign w_last = (r_idx == c_IDX_W'(c_NSL - 1));

    // Slice mux, one-slice add and merge of the new slice into the result
    always_comb begin
        w_x_slice     = '0;
        w_y_slice     = '0;
        w_result_next = r_result;
        for (int i = 0; i < c_NSL; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_x_slice = r_x[i*SLICE +: SLICE];
                w_y_slice = r_y[i*SLICE +: SLICE];
            end
        end
        w_sum = {1'b0, w_x_slice}
              + {1'b0, w_y_slice ^ {SLICE{r_sub}}}
              + {{SLICE{1'b0}}, r_carry};
        for (int i = 0; i < c_NSL; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_result_next[i*SLICE +: SLICE] = w_sum[SLICE-1:0];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_x      <= '0;
            r_y      <= '0;
            r_sub    <= 1'b0;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_x     <= x;
                r_y     <= y;
                r_sub   <= sub;
                r_idx   <= '0;
                // Carry-in of 1 completes the two's complement of y
                r_carry <= sub;
            end else if (r_state == S_RUN) begin
                r_result <= w_result_next;
                r_carry  <= w_sum[SLICE];
                r_idx    <= r_idx + c_IDX_W'(1);
                if (w_last) begin
                    r_cout <= w_sum[SLICE];
                end
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out       = r_result;
    assign carry_out = r_cout;

`ifdef SEQ_ADDSUB_FLAGS_EN
    logic r_zero;
    logic r_negative;
    logic r_overflow;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_zero     <= 1'b0;
            r_negative <= 1'b0;
            r_overflow <= 1'b0;
        end else if ((r_state == S_RUN) && w_last) begin
            r_zero     <= (w_result_next == '0);
            r_negative <= w_result_next[WIDTH-1];
            r_overflow <= (r_x[WIDTH-1] == (r_y[WIDTH-1] ^ r_sub))
                        & (w_result_next[WIDTH-1] != r_x[WIDTH-1]);
        end
    end

    assign zero     = r_zero;
    assign negative = r_negative;
    assign overflow = r_overflow;
`else
    assign zero     = 1'b0;
    assign negative = 1'b0;
    assign overflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_addsub
// Description : Randomized self-checking bench for seq_addsub (32/8 and 32/32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_addsub;

    localparam int W   = 32;
    localparam int S   = 8;
    localparam int NSL = W / S;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] x, y, out;
    logic         sub, carry_out, zero, negative, overflow;

    logic         in_valid1, in_ready1, out_valid1, out_ready1;
    logic [W-1:0] out1;
    logic         carry1, zero1, negative1, overflow1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_addsub #(.WIDTH(W), .SLICE(S)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .carry_out(carry_out), .zero(zero), .negative(negative),
        .overflow(overflow)
    );

    seq_addsub #(.WIDTH(W), .SLICE(W)) u_dut_single (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .x(x), .y(y), .sub(sub), .out_valid(out_valid1), .out_ready(out_ready1),
        .out(out1), .carry_out(carry1), .zero(zero1), .negative(negative1),
        .overflow(overflow1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] r, output logic c,
                                  output logic z, output logic n, output logic o);
        longint unsigned ua  = 64'(a);
        longint unsigned ub  = 64'(b);
        longint          sa  = longint'($signed(a));
        longint          sb  = longint'($signed(b));
        longint          lim = 64'sd1 <<< (W - 1);
        longint unsigned full;
        longint          ss;
        logic            ovf;
        if (!s) begin
            full = ua + ub;
            c    = full[W];
            ss   = sa + sb;
        end else begin
            full = ua - ub;
            c    = (ua >= ub);
            ss   = sa - sb;
        end
        r   = full[W-1:0];
        ovf = (ss >= lim) || (ss < -lim);
`ifdef SEQ_ADDSUB_FLAGS_EN
        z = (r == '0);
        n = r[W-1];
        o = ovf;
`else
        z = 1'b0;
        n = 1'b0;
        o = 1'b0;
        if (ovf) o = 1'b0;
`endif
    endfunction

    // Runs one operation on the 32/8 instance; called at #1 after a rising edge
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input int hold, input string tag);
        logic [W-1:0] er;
        logic         ec, ez, en, eo;
        int           lat;
        model(a, b, s, er, ec, ez, en, eo);
        check({tag, " in_ready_idle"}, 64'(in_ready), 64'd1);
        x = a; y = b; sub = s; in_valid = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (!out_valid && lat < 20) begin
            check({tag, " in_ready_busy"}, 64'(in_ready), 64'd0);
            x = $urandom; y = $urandom; sub = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        check({tag, " latency"}, 64'(lat), 64'(NSL));
        check({tag, " out"}, 64'(out), 64'(er));
        check({tag, " carry_out"}, 64'(carry_out), 64'(ec));
        check({tag, " flags"}, {61'd0, zero, negative, overflow}, {61'd0, ez, en, eo});
        repeat (hold) begin
            x = $urandom; y = $urandom; sub = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check({tag, " hold_out"}, {30'd0, out_valid, in_ready, out}, {30'd0, 2'b10, er});
            check({tag, " hold_carry"}, 64'(carry_out), 64'(ec));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " handoff"}, {62'd0, in_ready, out_valid}, 64'b10);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " rdy_vld"}, {62'd0, in_ready, out_valid}, 64'b10);
        check({tag, " out"}, 64'(out), 64'd0);
        check({tag, " carry_flags"}, {60'd0, carry_out, zero, negative, overflow}, 64'd0);
    endtask

    initial begin
        logic [W-1:0] er;
        logic         ec, ez, en, eo;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b0;
        x = '0; y = '0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        check("reset single rdy_vld", {62'd0, in_ready1, out_valid1}, 64'b10);
        rst_n = 1'b1;

        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 0, "add_ff_1");
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, "carry_all");
        run_op(32'd5,         32'd7,         1'b1, 1, "sub_borrow");
        run_op(32'd7,         32'd5,         1'b1, 0, "sub_noborrow");
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 2, "ovf_add");
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 0, "ovf_sub");
        run_op(32'h1234_5678, 32'h1234_5678, 1'b1, 0, "sub_equal");
        run_op($urandom, $urandom, 1'b0, 10, "backpressure");

        for (int i = 0; i < 40; i++) begin
            run_op($urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3), "random");
        end

        // Reset after the second RUN edge discards the operation
        x = 32'h0000_1111; y = 32'h0000_2222; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_reset_state("rst_run");
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("rst_run quiet", {62'd0, in_ready, out_valid}, 64'b10);
        end

        // Reset in DONE beats a simultaneous out_ready
        x = 32'hFFFF_FFFF; y = 32'h0000_0001; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (NSL) @(posedge clk);
        #1;
        check("rst_done pre_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b0;
        check_reset_state("rst_done");

        run_op(32'hDEAD_BEEF, 32'h0000_0011, 1'b1, 0, "after_reset");

        // Single-slice instance: one RUN cycle
        for (int i = 0; i < 6; i++) begin
            x = (i == 0) ? 32'h7FFF_FFFF : 32'($urandom);
            y = (i == 0) ? 32'h0000_0001 : 32'($urandom);
            sub = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            model(x, y, sub, er, ec, ez, en, eo);
            check("single in_ready", 64'(in_ready1), 64'd1);
            in_valid1 = 1'b1;
            @(posedge clk); #1;
            in_valid1 = 1'b0;
            check("single busy", 64'(out_valid1), 64'd0);
            @(posedge clk); #1;
            check("single latency", 64'(out_valid1), 64'd1);
            check("single out", 64'(out1), 64'(er));
            check("single carry_flags", {60'd0, carry1, zero1, negative1, overflow1},
                  {60'd0, ec, ez, en, eo});
            out_ready1 = 1'b1;
            @(posedge clk); #1;
            out_ready1 = 1'b0;
            check("single handoff", {62'd0, in_ready1, out_valid1}, 64'b10);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
